sram_arbiter: RTL and testbench
===============================

// Module: sram_arbiter
// PURPOSE
//   Two-port arbiter/sequencer for the external 16-bit async SRAM (20-bit addr, active-low CE/UB/LB/OE/WE).
//   Shares the SRAM between a read port (VGA scanout fetch) and a write port (rasterizer pixel writes).
//   Sequences every access as a fixed multi-cycle FSM and owns the tristate DQ bus.
//   Read port has priority; a starvation counter guarantees the write port forward progress.
// PARAMETERS
//   ADDR_W           20  SRAM address width
//   DATA_W           16  SRAM data width; must be 16 (two byte lanes)
//   WR_STARVE_LIMIT  4   consecutive lost arbitrations before write is forced; legal range >= 1
// PORTS
//   clock_100  in     1       system clock; all logic on posedge
//   reset_n    in     1       synchronous, active-low reset
//   rd_req     in     1       read request; hold with rd_addr until rd_ack
//   rd_addr    in     ADDR_W  read word address
//   rd_ack     out    1       one-cycle pulse: read accepted
//   rd_valid   out    1       one-cycle pulse: rd_data valid
//   rd_data    out    DATA_W  read data; holds until next rd_valid
//   wr_req     in     1       write request; hold with wr_addr/wr_data/wr_be until wr_ack
//   wr_addr    in     ADDR_W  write word address
//   wr_data    in     DATA_W  write data
//   wr_be      in     2       byte enables, active high; [1]=upper, [0]=lower
//   wr_ack     out    1       one-cycle pulse: write accepted
//   wr_done    out    1       one-cycle pulse: write committed
//   SRAM_ADDR  out    ADDR_W  SRAM address
//   SRAM_DQ    inout  DATA_W  SRAM data; driven only in WRITE1/WRITE2, else 'Z
//   SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  SRAM strobes, active low
// BEHAVIOUR
//   Reset (reset_n=0 at posedge)
//   - State=IDLE; all SRAM strobes=1; SRAM_ADDR=0; DQ released.
//   - rd_ack=rd_valid=wr_ack=wr_done=0; rd_data=0; starve_cnt=0.
//   - Reset mid-access aborts the access; no done/valid pulse is produced.
//   All outputs are registered. FSM states: IDLE, READ1, READ2, WRITE1, WRITE2.
//   IDLE (arbitration; sampled at each posedge)
//   - Grant read if rd_req && !(wr_req && starve_cnt==WR_STARVE_LIMIT).
//   - Else grant write if wr_req.
//   - Else stay in IDLE with all strobes=1.
//   - starve_cnt: +1 when read is granted while wr_req=1; cleared on write grant or when wr_req=0.
//   - starve_cnt saturates at WR_STARVE_LIMIT.
//   Read, granted at edge E0
//   - READ1 (after E0): SRAM_ADDR=rd_addr, CE_N=OE_N=UB_N=LB_N=0, WE_N=1, rd_ack=1.
//   - READ2 (after E1): strobes held; SRAM drives DQ.
//   - IDLE (after E2): rd_data<=SRAM_DQ, rd_valid=1, all strobes=1.
//   - rd_ack->rd_valid = 2 cycles; req sample->rd_valid = 3 cycles.
//   Write, granted at edge E0
//   - WRITE1 (after E0): SRAM_ADDR=wr_addr, DQ=wr_data, CE_N=0, OE_N=1, WE_N=1,
//     UB_N=~wr_be[1], LB_N=~wr_be[0], wr_ack=1.
//   - WRITE2 (after E1): WE_N=0; SRAM commits at E2.
//   - IDLE (after E2): wr_done=1, strobes=1, DQ released.
//   - wr_be=2'b00 still runs the full sequence (no bytes change); wr_done still pulses.
//   Throughput and turnaround
//   - Every access returns through one IDLE cycle: max one access per 3 cycles.
//   - The IDLE cycle is the bus turnaround; OE_N and WE_N are never both 0.
//   - DQ is never driven while OE_N=0.
//   Requester rules
//   - Requests are sampled only in IDLE; a request dropped before ack is simply not served.
//   - Requester deasserts or changes request after seeing ack.
//   - Address/data are latched at grant; later input changes do not affect the access.
// TESTING
//   1 Reset: hold reset_n=0 mid-WRITE2 -> next cycle strobes all 1, DQ='Z, no wr_done, state IDLE.
//   2 Single read: model preloaded mem[0x00ABC]=16'h1234; rd_req @0x00ABC
//     -> rd_ack 1 cycle after sample edge; rd_valid 2 cycles later; rd_data=16'h1234.
//   3 Byte write: write 16'hBEEF wr_be=2'b11 @0x00010, then 16'h55AA wr_be=2'b01
//     -> readback 16'hBEAA; UB_N=1 during the second write.
//   4 Contention: rd_req and wr_req held high continuously, WR_STARVE_LIMIT=4
//     -> grant order R,R,R,R,W,R,R,R,R,W...; each access spaced exactly 3 cycles.
//   5 Back-to-back: alternating W@0x00020=16'hCAFE then R@0x00020
//     -> rd_data=16'hCAFE; checker asserts no DQ contention and no OE_N=WE_N=0 overlap.
//   6 Bus float: no requests for 20 cycles -> CE_N=1, SRAM_DQ='Z, no ack/valid/done pulses.

Source files
------------

// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
//
// Shares one external 16-bit asynchronous SRAM between a read port (display
// scanout fetch) and a write port (rasterizer pixel writes). Every access runs
// as a fixed three-cycle sequence (two active cycles plus one IDLE cycle that
// doubles as the bus turnaround). The read port wins arbitration unless the
// write port has already lost WR_STARVE_LIMIT consecutive arbitrations, in
// which case the write is forced through.
//
// Ports
//   clock_100               system clock, all logic on posedge
//   reset_n                 synchronous active-low reset
//   rd_req/rd_addr          read request + word address (held until rd_ack)
//   rd_ack                  one-cycle pulse, read accepted
//   rd_valid/rd_data        one-cycle pulse + read data (data held until next valid)
//   wr_req/wr_addr/wr_data  write request + address + data (held until wr_ack)
//   wr_be                   byte enables, active high, [1]=upper [0]=lower
//   wr_ack                  one-cycle pulse, write accepted
//   wr_done                 one-cycle pulse, write committed to the SRAM
//   SRAM_*                  SRAM address, bidirectional data, active-low strobes
// -----------------------------------------------------------------------------
module sram_arbiter #(
  parameter int ADDR_W          = 20,
  parameter int DATA_W          = 16,
  parameter int WR_STARVE_LIMIT = 4
) (
  input  logic              clock_100,
  input  logic              reset_n,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [1:0]        wr_be,
  output logic              wr_ack,
  output logic              wr_done,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N
);

  localparam int CNT_W = $clog2(WR_STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(WR_STARVE_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ1,
    S_READ2,
    S_WRITE1,
    S_WRITE2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    starve_q, starve_d;
  logic [DATA_W-1:0]   dq_out_q, dq_out_d;
  logic                dq_oe_q, dq_oe_d;

  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   rd_data_d;
  logic                ce_n_d, oe_n_d, we_n_d, ub_n_d, lb_n_d;
  logic                rd_ack_d, rd_valid_d, wr_ack_d, wr_done_d;
  logic                grant_rd;

  // The data bus is only ever driven during the two write cycles; the IDLE
  // cycle after every access guarantees the SRAM has released it first.
  assign SRAM_DQ = dq_oe_q ? dq_out_q : 'z;

  // Read wins unless the waiting write has already been passed over the
  // maximum number of times.
  assign grant_rd = rd_req && !(wr_req && (starve_q == STARVE_MAX));

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    starve_d   = starve_q;
    dq_out_d   = dq_out_q;
    dq_oe_d    = 1'b0;
    addr_d     = SRAM_ADDR;
    rd_data_d  = rd_data;
    ce_n_d     = 1'b1;
    oe_n_d     = 1'b1;
    we_n_d     = 1'b1;
    ub_n_d     = 1'b1;
    lb_n_d     = 1'b1;
    rd_ack_d   = 1'b0;
    rd_valid_d = 1'b0;
    wr_ack_d   = 1'b0;
    wr_done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (grant_rd) begin
          state_d  = S_READ1;
          addr_d   = rd_addr;
          ce_n_d   = 1'b0;
          oe_n_d   = 1'b0;
          ub_n_d   = 1'b0;
          lb_n_d   = 1'b0;
          rd_ack_d = 1'b1;
          // Count only arbitrations the write actually lost; saturate.
          if (!wr_req)
            starve_d = '0;
          else if (starve_q != STARVE_MAX)
            starve_d = starve_q + 1'b1;
        end else if (wr_req) begin
          state_d  = S_WRITE1;
          addr_d   = wr_addr;
          dq_out_d = wr_data;
          dq_oe_d  = 1'b1;
          ce_n_d   = 1'b0;
          ub_n_d   = ~wr_be[1];
          lb_n_d   = ~wr_be[0];
          wr_ack_d = 1'b1;
          starve_d = '0;
        end else begin
          starve_d = '0;
        end
      end
      S_READ1: begin
        state_d = S_READ2;
        ce_n_d  = 1'b0;
        oe_n_d  = 1'b0;
        ub_n_d  = 1'b0;
        lb_n_d  = 1'b0;
      end
      S_READ2: begin
        // The SRAM has driven DQ for a full cycle by this edge.
        state_d    = S_IDLE;
        rd_data_d  = SRAM_DQ;
        rd_valid_d = 1'b1;
      end
      S_WRITE1: begin
        state_d = S_WRITE2;
        dq_oe_d = 1'b1;
        ce_n_d  = 1'b0;
        we_n_d  = 1'b0;
        ub_n_d  = SRAM_UB_N;
        lb_n_d  = SRAM_LB_N;
      end
      S_WRITE2: begin
        // WE_N rises here with address and data still stable.
        state_d   = S_IDLE;
        wr_done_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_100) begin
    // NOTE: state and outputs use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset_n) begin
      state_q   <= S_IDLE;
      starve_q  <= '0;
      dq_out_q  <= '0;
      dq_oe_q   <= 1'b0;
      SRAM_ADDR <= '0;
      SRAM_CE_N <= 1'b1;
      SRAM_OE_N <= 1'b1;
      SRAM_WE_N <= 1'b1;
      SRAM_UB_N <= 1'b1;
      SRAM_LB_N <= 1'b1;
      rd_ack    <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      wr_ack    <= 1'b0;
      wr_done   <= 1'b0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      dq_out_q  <= dq_out_d;
      dq_oe_q   <= dq_oe_d;
      SRAM_ADDR <= addr_d;
      SRAM_CE_N <= ce_n_d;
      SRAM_OE_N <= oe_n_d;
      SRAM_WE_N <= we_n_d;
      SRAM_UB_N <= ub_n_d;
      SRAM_LB_N <= lb_n_d;
      rd_ack    <= rd_ack_d;
      rd_valid  <= rd_valid_d;
      rd_data   <= rd_data_d;
      wr_ack    <= wr_ack_d;
      wr_done   <= wr_done_d;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_arbiter
//
// Drives sram_arbiter against a simple asynchronous SRAM device model and
// checks every cycle against a transaction-level reference: each grant is
// recorded as (kind, edge, address, data, byte enables) and the expected pins
// are derived from how many edges have passed since that grant. A reference
// memory tracks what the SRAM must contain. When the SRAM is deselected the
// device model drives a fixed pattern on DQ, so a DQ value other than that
// pattern while CE_N=1 exposes the arbiter driving the bus.
// -----------------------------------------------------------------------------
module tb_sram_arbiter;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;
  localparam int LIMIT  = 4;
  localparam logic [15:0] FLOAT_PAT = 16'h5A5A;

  logic              clock_100 = 1'b0;
  logic              reset_n   = 1'b0;
  logic              rd_req    = 1'b0;
  logic [ADDR_W-1:0] rd_addr   = '0;
  logic              rd_ack, rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              wr_req    = 1'b0;
  logic [ADDR_W-1:0] wr_addr   = '0;
  logic [DATA_W-1:0] wr_data   = '0;
  logic [1:0]        wr_be     = '0;
  logic              wr_ack, wr_done;
  logic [ADDR_W-1:0] SRAM_ADDR;
  wire  [DATA_W-1:0] SRAM_DQ;
  logic              SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;

  sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WR_STARVE_LIMIT(LIMIT)) dut (
    .clock_100 (clock_100),
    .reset_n   (reset_n),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_ack    (rd_ack),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_be     (wr_be),
    .wr_ack    (wr_ack),
    .wr_done   (wr_done),
    .SRAM_ADDR (SRAM_ADDR),
    .SRAM_DQ   (SRAM_DQ),
    .SRAM_CE_N (SRAM_CE_N),
    .SRAM_OE_N (SRAM_OE_N),
    .SRAM_WE_N (SRAM_WE_N),
    .SRAM_UB_N (SRAM_UB_N),
    .SRAM_LB_N (SRAM_LB_N)
  );

  always #5 clock_100 = ~clock_100;

  // ---------------- scoring ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- SRAM device model (low 12 address bits decoded) ----------------
  logic [15:0] env_mem [0:4095];
  wire env_rd = !SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N;
  assign SRAM_DQ = env_rd    ? env_mem[SRAM_ADDR[11:0]] : 'z;
  assign SRAM_DQ = SRAM_CE_N ? FLOAT_PAT                : 'z;

  always @(posedge clock_100) begin
    if (!SRAM_CE_N && !SRAM_WE_N) begin
      if (!SRAM_UB_N) env_mem[SRAM_ADDR[11:0]][15:8] <= SRAM_DQ[15:8];
      if (!SRAM_LB_N) env_mem[SRAM_ADDR[11:0]][7:0]  <= SRAM_DQ[7:0];
    end
  end

  // ---------------- transaction-level reference ----------------
  logic [15:0] ref_mem [0:4095];
  int          cyc = 0;
  bit          act = 0;
  bit          g_wr;
  int          g_edge;
  logic [19:0] g_addr;
  logic [15:0] g_data;
  logic [1:0]  g_be;
  int          next_free = 0;
  int          lost = 0;          // arbitrations the waiting write has lost in a row
  bit          addr_is_reset = 0;
  bit          chk_en = 0;

  logic        e_ce, e_oe, e_we, e_ub, e_lb;
  logic        e_rack, e_rval, e_wack, e_wdone;
  logic [15:0] e_rd_data = '0;
  logic [15:0] e_dq;
  logic [19:0] e_addr = '0;
  bit          e_addr_chk;

  always @(posedge clock_100) begin : ref_model
    int k;
    cyc++;
    // A write commits at the edge that ends its WE_N-low cycle, reset or not.
    if (act && g_wr && (cyc - g_edge == 2)) begin
      if (g_be[1]) ref_mem[g_addr[11:0]][15:8] = g_data[15:8];
      if (g_be[0]) ref_mem[g_addr[11:0]][7:0]  = g_data[7:0];
    end
    if (!reset_n) begin
      act = 0; next_free = cyc + 1; lost = 0;
      e_rd_data = '0; e_addr = '0; addr_is_reset = 1; chk_en = 1;
    end else begin
      if (act && !g_wr && (cyc - g_edge == 2)) e_rd_data = ref_mem[g_addr[11:0]];
      if (cyc >= next_free) begin
        if (rd_req && !(wr_req && lost == LIMIT)) begin
          act = 1; g_wr = 0; g_edge = cyc; g_addr = rd_addr;
          lost = wr_req ? ((lost < LIMIT) ? lost + 1 : lost) : 0;
          next_free = cyc + 3; addr_is_reset = 0;
        end else if (wr_req) begin
          act = 1; g_wr = 1; g_edge = cyc; g_addr = wr_addr; g_data = wr_data; g_be = wr_be;
          lost = 0; next_free = cyc + 3; addr_is_reset = 0;
        end else begin
          lost = 0;
        end
      end
    end
    // Expected pins for the cycle following this edge.
    {e_ce, e_oe, e_we, e_ub, e_lb} = 5'b11111;
    {e_rack, e_rval, e_wack, e_wdone} = 4'b0000;
    e_dq = FLOAT_PAT;
    e_addr_chk = addr_is_reset;
    k = act ? cyc - g_edge : 99;
    if (k <= 1) begin
      e_addr = g_addr; e_addr_chk = 1; e_ce = 0;
      if (!g_wr) begin
        e_oe = 0; e_ub = 0; e_lb = 0; e_rack = (k == 0);
        e_dq = ref_mem[g_addr[11:0]];
      end else begin
        e_we = (k == 1) ? 1'b0 : 1'b1;
        e_ub = ~g_be[1]; e_lb = ~g_be[0]; e_wack = (k == 0);
        e_dq = g_data;
      end
    end else if (k == 2) begin
      if (g_wr) e_wdone = 1; else e_rval = 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clock_100) begin
    if (chk_en) begin
      check("ce_n",     SRAM_CE_N, e_ce);
      check("oe_n",     SRAM_OE_N, e_oe);
      check("we_n",     SRAM_WE_N, e_we);
      check("ub_n",     SRAM_UB_N, e_ub);
      check("lb_n",     SRAM_LB_N, e_lb);
      check("rd_ack",   rd_ack,    e_rack);
      check("rd_valid", rd_valid,  e_rval);
      check("wr_ack",   wr_ack,    e_wack);
      check("wr_done",  wr_done,   e_wdone);
      check("rd_data",  rd_data,   e_rd_data);
      check("dq",       SRAM_DQ,   e_dq);
      check("oe_we_overlap", 32'(!SRAM_OE_N && !SRAM_WE_N), 0);
      if (e_addr_chk) check("addr", SRAM_ADDR, e_addr);
    end
  end

  // ---------------- ack log for the contention test ----------------
  bit   log_en = 0;
  byte  log_kind[$];
  int   log_cyc[$];
  always @(negedge clock_100) begin
    if (log_en) begin
      if (rd_ack) begin log_kind.push_back("R"); log_cyc.push_back(cyc); end
      if (wr_ack) begin log_kind.push_back("W"); log_cyc.push_back(cyc); end
    end
  end

  // ---------------- requester tasks ----------------
  task automatic do_read(input logic [19:0] a, output logic [15:0] d,
                         output int req_to_ack, output int ack_to_valid);
    int n;
    @(negedge clock_100);
    rd_addr = a; rd_req = 1'b1;
    n = 0;
    while (!rd_ack && n < 20) begin @(negedge clock_100); n++; end
    check("rd_ack_timeout", 32'(n < 20), 1);
    req_to_ack = n;
    rd_req = 1'b0; rd_addr = 20'($urandom);
    n = 0;
    while (!rd_valid && n < 20) begin @(negedge clock_100); n++; end
    check("rd_valid_timeout", 32'(n < 20), 1);
    ack_to_valid = n;
    d = rd_data;
  endtask

  task automatic do_write(input logic [19:0] a, input logic [15:0] d, input logic [1:0] be,
                          output logic ub_at_ack);
    int n;
    @(negedge clock_100);
    wr_addr = a; wr_data = d; wr_be = be; wr_req = 1'b1;
    n = 0;
    while (!wr_ack && n < 20) begin @(negedge clock_100); n++; end
    check("wr_ack_timeout", 32'(n < 20), 1);
    ub_at_ack = SRAM_UB_N;
    wr_req = 1'b0; wr_addr = 20'($urandom); wr_data = 16'($urandom); wr_be = 2'($urandom);
    n = 0;
    while (!wr_done && n < 20) begin @(negedge clock_100); n++; end
    check("wr_done_timeout", 32'(n < 20), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [15:0] d;
    logic        ub;
    int          t_req, t_val, n, pulses;
    logic [19:0] pool [8];
    string       exp_pat;

    for (int i = 0; i < 4096; i++) begin env_mem[i] = '0; ref_mem[i] = '0; end
    env_mem[12'hABC] = 16'h1234;
    ref_mem[12'hABC] = 16'h1234;

    repeat (3) @(negedge clock_100);
    check("reset_ce_n", SRAM_CE_N, 1);
    check("reset_addr", SRAM_ADDR, 0);
    reset_n = 1'b1;

    // Single read of preloaded word.
    do_read(20'h00ABC, d, t_req, t_val);
    check("t2_rd_data", d, 16'h1234);
    check("t2_req_to_ack", t_req, 1);
    check("t2_ack_to_valid", t_val, 2);

    // Byte-lane write.
    do_write(20'h00010, 16'hBEEF, 2'b11, ub);
    do_write(20'h00010, 16'h55AA, 2'b01, ub);
    check("t3_ub_n_second_write", ub, 1);
    do_read(20'h00010, d, t_req, t_val);
    check("t3_readback", d, 16'hBEAA);

    // Back-to-back write then read of the same word.
    @(negedge clock_100);
    wr_addr = 20'h00020; wr_data = 16'hCAFE; wr_be = 2'b11; wr_req = 1'b1;
    n = 0;
    while (!wr_ack && n < 20) begin @(negedge clock_100); n++; end
    check("t5_wr_ack_timeout", 32'(n < 20), 1);
    wr_req = 1'b0; rd_addr = 20'h00020; rd_req = 1'b1;
    n = 0;
    while (!rd_ack && n < 20) begin @(negedge clock_100); n++; end
    check("t5_wr_to_rd_spacing", n, 3);
    rd_req = 1'b0;
    n = 0;
    while (!rd_valid && n < 20) begin @(negedge clock_100); n++; end
    check("t5_readback", rd_data, 16'hCAFE);

    // Random single-port traffic over a small address pool, including wr_be=0.
    for (int i = 0; i < 8; i++) pool[i] = 20'($urandom);
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(1, 0) == 1)
        do_write(pool[$urandom_range(7, 0)], 16'($urandom), 2'($urandom), ub);
      else
        do_read(pool[$urandom_range(7, 0)], d, t_req, t_val);
    end
    do_write(pool[0], 16'hFFFF, 2'b00, ub);

    // Contention: both requests held; write forced every LIMIT+1 grants.
    @(negedge clock_100);
    log_en = 1;
    rd_addr = 20'($urandom); wr_addr = 20'($urandom); wr_data = 16'($urandom); wr_be = 2'b11;
    rd_req = 1'b1; wr_req = 1'b1;
    n = 0;
    while (log_kind.size() < 10 && n < 100) begin @(negedge clock_100); n++; end
    check("t4_timeout", 32'(n < 100), 1);
    rd_req = 1'b0; wr_req = 1'b0;
    log_en = 0;
    exp_pat = "RRRRWRRRRW";
    for (int i = 0; i < 10 && i < log_kind.size(); i++) begin
      check($sformatf("t4_grant_%0d", i), log_kind[i], exp_pat[i]);
      if (i > 0) check($sformatf("t4_spacing_%0d", i), log_cyc[i] - log_cyc[i-1], 3);
    end
    repeat (4) @(negedge clock_100);

    // Bus float: nothing requested for 20 cycles.
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock_100);
      pulses += int'(rd_ack) + int'(rd_valid) + int'(wr_ack) + int'(wr_done);
      check("t6_ce_n", SRAM_CE_N, 1);
      check("t6_dq_float", SRAM_DQ, FLOAT_PAT);
    end
    check("t6_pulses", pulses, 0);

    // Reset in the middle of WRITE2.
    @(negedge clock_100);
    wr_addr = 20'hFFF00; wr_data = 16'h1357; wr_be = 2'b11; wr_req = 1'b1;
    n = 0;
    while (!wr_ack && n < 20) begin @(negedge clock_100); n++; end
    check("t1_wr_ack_timeout", 32'(n < 20), 1);
    wr_req = 1'b0;
    @(negedge clock_100);
    check("t1_in_write2", SRAM_WE_N, 0);
    reset_n = 1'b0;
    @(negedge clock_100);
    check("t1_ce_n", SRAM_CE_N, 1);
    check("t1_we_n", SRAM_WE_N, 1);
    check("t1_oe_n", SRAM_OE_N, 1);
    check("t1_dq_float", SRAM_DQ, FLOAT_PAT);
    check("t1_no_done", wr_done, 0);
    @(negedge clock_100);
    check("t1_no_done_late", wr_done, 0);
    reset_n = 1'b1;
    do_read(20'h00020, d, t_req, t_val);
    check("t1_after_reset_read", d, 16'hCAFE);
    repeat (3) @(negedge clock_100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
